// File: rtl/lsu_mem_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module   : lsu_mem_ctrl_pkg
// Purpose  : Shared definitions for the load/store controller: memory access
//            size codes (identical to the data memory mode decode), FSM state
//            encoding and the request alignment check.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package lsu_mem_ctrl_pkg;

  // Access size codes, bit-identical to the data memory mode port.
  localparam logic [1:0] SZ_WORD    = 2'b00;
  localparam logic [1:0] SZ_BYTE    = 2'b01;
  localparam logic [1:0] SZ_HALF    = 2'b10;
  localparam logic [1:0] SZ_ILLEGAL = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'b00,
    ST_ACCESS = 2'b01,
    ST_RESP   = 2'b10
  } state_t;

  // True when a request must be rejected without touching memory:
  // illegal size, odd half-word address, or word address not 4-aligned.
  function automatic logic req_misaligned(input logic [1:0] size,
                                          input logic [1:0] addr_lo);
    logic bad;
    bad = 1'b0;
    case (size)
      SZ_WORD: bad = (addr_lo != 2'b00);
      SZ_HALF: bad = addr_lo[0];
      SZ_BYTE: bad = 1'b0;
      default: bad = 1'b1;
    endcase
    return bad;
  endfunction

endpackage
`default_nettype wire

// File: rtl/lsu_mem_ctrl_load_extend.sv
`default_nettype none
// ============================================================================
// Module   : lsu_mem_ctrl_load_extend
// Purpose  : Combinational sign/zero extension of right-aligned load data.
//            Kept standalone so an uncached I/O path can reuse it.
// Ports    : size     in  2   access size code (word/byte/half)
//            sign_ext in  1   1 = sign-extend, 0 = zero-extend
//            din      in  32  right-aligned raw read data
//            dout     out 32  extended data
// Revision : 1.0 - initial release
// ============================================================================
module lsu_mem_ctrl_load_extend
  import lsu_mem_ctrl_pkg::*;
(
  input  logic [1:0]  size,
  input  logic        sign_ext,
  input  logic [31:0] din,
  output logic [31:0] dout
);

  always_comb begin
    dout = din;
    case (size)
      SZ_BYTE: dout = sign_ext ? {{24{din[7]}}, din[7:0]}   : {24'b0, din[7:0]};
      SZ_HALF: dout = sign_ext ? {{16{din[15]}}, din[15:0]} : {16'b0, din[15:0]};
      default: dout = din;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/lsu_mem_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : lsu_mem_ctrl
// Purpose  : Load/store controller in front of the byte-addressable data
//            memory. Takes one request at a time, rejects misaligned or
//            illegal-size requests, drives the memory for exactly one cycle,
//            extends load data and returns a response. Keeps saturating
//            load/store/error counters.
// Ports    : clk, clr_n                 clock, async active-low reset
//            req_valid/req_ready        request handshake
//            req_we, req_size, req_signed, req_addr, req_wdata  request fields
//            rsp_valid/rsp_ready        response handshake
//            rsp_rdata, rsp_err         response payload
//            mem_str, mem_mode, mem_addr, mem_din, mem_dout  memory port
//            cnt_load, cnt_store, cnt_err  saturating event counters
// Revision : 1.0 - initial release
// ============================================================================
module lsu_mem_ctrl
  import lsu_mem_ctrl_pkg::*;
#(
  parameter int AWIDTH = 12,
  parameter int DWIDTH = 32,
  parameter int CWIDTH = 16
) (
  input  logic              clk,
  input  logic              clr_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [1:0]        req_size,
  input  logic              req_signed,
  input  logic [AWIDTH-1:0] req_addr,
  input  logic [DWIDTH-1:0] req_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DWIDTH-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic              mem_str,
  output logic [1:0]        mem_mode,
  output logic [AWIDTH-1:0] mem_addr,
  output logic [DWIDTH-1:0] mem_din,
  input  logic [DWIDTH-1:0] mem_dout,
  output logic [CWIDTH-1:0] cnt_load,
  output logic [CWIDTH-1:0] cnt_store,
  output logic [CWIDTH-1:0] cnt_err
);

  localparam logic [CWIDTH-1:0] c_cnt_one = CWIDTH'(1);

  state_t              r_state;
  state_t              w_state_nxt;

  logic                r_we;
  logic [1:0]          r_size;
  logic                r_sign;
  logic [AWIDTH-1:0]   r_addr;
  logic [DWIDTH-1:0]   r_wdata;
  logic [DWIDTH-1:0]   r_rdata;
  logic                r_err;
  logic [CWIDTH-1:0]   r_cnt_load;
  logic [CWIDTH-1:0]   r_cnt_store;
  logic [CWIDTH-1:0]   r_cnt_err;

  logic                w_req_bad;
  logic [DWIDTH-1:0]   w_load_ext;

  function automatic logic [CWIDTH-1:0] sat_inc(input logic [CWIDTH-1:0] v);
    return (&v) ? v : v + c_cnt_one;
  endfunction

  assign w_req_bad = req_misaligned(req_size, req_addr[1:0]);

  // Extension uses the registered size/sign so the captured value matches
  // the access actually presented to the memory.
  lsu_mem_ctrl_load_extend u_load_extend (
    .size     (r_size),
    .sign_ext (r_sign),
    .din      (mem_dout),
    .dout     (w_load_ext)
  );

  // --------------------------------------------------------------------------
  // FSM state register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // --------------------------------------------------------------------------
  // FSM next-state and handshake/strobe decode. All three outputs depend on
  // state only, so reset drops mem_str immediately and rsp_ready never
  // reaches req_ready combinationally.
  // --------------------------------------------------------------------------
  always_comb begin
    w_state_nxt = r_state;
    req_ready   = 1'b0;
    rsp_valid   = 1'b0;
    mem_str     = 1'b0;
    case (r_state)
      ST_IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          w_state_nxt = w_req_bad ? ST_RESP : ST_ACCESS;
        end
      end
      ST_ACCESS: begin
        mem_str     = r_we;
        w_state_nxt = ST_RESP;
      end
      ST_RESP: begin
        rsp_valid = 1'b1;
        if (rsp_ready) begin
          w_state_nxt = ST_IDLE;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // Request capture, response data and counters
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      r_we        <= 1'b0;
      r_size      <= SZ_WORD;
      r_sign      <= 1'b0;
      r_addr      <= '0;
      r_wdata     <= '0;
      r_rdata     <= '0;
      r_err       <= 1'b0;
      r_cnt_load  <= '0;
      r_cnt_store <= '0;
      r_cnt_err   <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (req_valid) begin
            r_we    <= req_we;
            r_size  <= req_size;
            r_sign  <= req_signed;
            r_addr  <= req_addr;
            r_wdata <= req_wdata;
            r_err   <= w_req_bad;
            r_rdata <= '0;
            if (w_req_bad) begin
              r_cnt_err <= sat_inc(r_cnt_err);
            end
          end
        end
        ST_ACCESS: begin
          // mem_dout is valid for the registered address during ACCESS;
          // this edge is also the one on which a store is written.
          r_rdata <= r_we ? '0 : w_load_ext;
          if (r_we) begin
            r_cnt_store <= sat_inc(r_cnt_store);
          end else begin
            r_cnt_load <= sat_inc(r_cnt_load);
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign rsp_rdata = r_rdata;
  assign rsp_err   = r_err;
  assign mem_mode  = r_size;
  assign mem_addr  = r_addr;
  assign mem_din   = r_wdata;
  assign cnt_load  = r_cnt_load;
  assign cnt_store = r_cnt_store;
  assign cnt_err   = r_cnt_err;

endmodule
`default_nettype wire

// File: tb/tb_lsu_mem_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_lsu_mem_ctrl
// Purpose  : Self-checking bench for lsu_mem_ctrl with a little-endian
//            byte-addressable memory model and a response scoreboard.
// Revision : 1.0 - initial release
// ============================================================================
module tb_lsu_mem_ctrl;
  import lsu_mem_ctrl_pkg::*;

  logic        clk;
  logic        clr_n;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [1:0]  req_size;
  logic        req_signed;
  logic [11:0] req_addr;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic        mem_str;
  logic [1:0]  mem_mode;
  logic [11:0] mem_addr;
  logic [31:0] mem_din;
  logic [31:0] mem_dout;
  logic [15:0] cnt_load;
  logic [15:0] cnt_store;
  logic [15:0] cnt_err;

  // Second instance with 2-bit counters: saturates after three events.
  logic        s_req_ready;
  logic        s_rsp_valid;
  logic [31:0] s_rsp_rdata;
  logic        s_rsp_err;
  logic        s_mem_str;
  logic [1:0]  s_mem_mode;
  logic [11:0] s_mem_addr;
  logic [31:0] s_mem_din;
  logic [1:0]  s_cnt_load;
  logic [1:0]  s_cnt_store;
  logic [1:0]  s_cnt_err;

  int          checks   = 0;
  int          failures = 0;
  int          str_cycles = 0;
  int          exp_loads  = 0;
  int          exp_stores = 0;
  int          exp_errs   = 0;
  logic [32:0] exp_q[$];
  logic [32:0] mon_exp;
  logic        mem_fill;
  logic [7:0]  mem_bytes [0:4095];

  lsu_mem_ctrl #(.AWIDTH(12), .DWIDTH(32), .CWIDTH(16)) dut (
    .clk(clk), .clr_n(clr_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_size(req_size), .req_signed(req_signed), .req_addr(req_addr),
    .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .rsp_err(rsp_err),
    .mem_str(mem_str), .mem_mode(mem_mode), .mem_addr(mem_addr),
    .mem_din(mem_din), .mem_dout(mem_dout),
    .cnt_load(cnt_load), .cnt_store(cnt_store), .cnt_err(cnt_err)
  );

  lsu_mem_ctrl #(.AWIDTH(12), .DWIDTH(32), .CWIDTH(2)) dut_sat (
    .clk(clk), .clr_n(clr_n),
    .req_valid(req_valid), .req_ready(s_req_ready), .req_we(req_we),
    .req_size(req_size), .req_signed(req_signed), .req_addr(req_addr),
    .req_wdata(req_wdata),
    .rsp_valid(s_rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(s_rsp_rdata),
    .rsp_err(s_rsp_err),
    .mem_str(s_mem_str), .mem_mode(s_mem_mode), .mem_addr(s_mem_addr),
    .mem_din(s_mem_din), .mem_dout(mem_dout),
    .cnt_load(s_cnt_load), .cnt_store(s_cnt_store), .cnt_err(s_cnt_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Little-endian memory: lane shifting happens here, data port is right-aligned.
  always @(posedge clk) begin
    if (mem_fill) begin
      for (int i = 0; i < 4096; i++) mem_bytes[i] <= i[7:0];
    end else if (mem_str) begin
      case (mem_mode)
        SZ_BYTE: mem_bytes[mem_addr] <= mem_din[7:0];
        SZ_HALF: begin
          mem_bytes[mem_addr]         <= mem_din[7:0];
          mem_bytes[mem_addr + 12'd1] <= mem_din[15:8];
        end
        default: begin
          mem_bytes[mem_addr]         <= mem_din[7:0];
          mem_bytes[mem_addr + 12'd1] <= mem_din[15:8];
          mem_bytes[mem_addr + 12'd2] <= mem_din[23:16];
          mem_bytes[mem_addr + 12'd3] <= mem_din[31:24];
        end
      endcase
    end
  end

  always_comb begin
    mem_dout = 32'h0;
    case (mem_mode)
      SZ_BYTE: mem_dout = {24'h0, mem_bytes[mem_addr]};
      SZ_HALF: mem_dout = {16'h0, mem_bytes[mem_addr + 12'd1], mem_bytes[mem_addr]};
      default: mem_dout = {mem_bytes[mem_addr + 12'd3], mem_bytes[mem_addr + 12'd2],
                           mem_bytes[mem_addr + 12'd1], mem_bytes[mem_addr]};
    endcase
  end

  always @(negedge clk) if (mem_str) str_cycles++;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h at %0t", name, got, exp, $time);
    end
  endtask

  // Scoreboard monitor: one pop per completed response handshake.
  always @(negedge clk) begin
    if (rsp_valid && rsp_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL rsp_unexpected got rdata=%h err=%b exp no response", rsp_rdata, rsp_err);
      end else begin
        mon_exp = exp_q.pop_front();
        chk("rsp_err", 32'(rsp_err), 32'(mon_exp[32]));
        chk("rsp_rdata", rsp_rdata, mon_exp[31:0]);
      end
    end
  end

  task automatic check_reset_vals();
    chk("rst_req_ready", 32'(req_ready), 32'd1);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_rsp_rdata", rsp_rdata, 32'd0);
    chk("rst_rsp_err", 32'(rsp_err), 32'd0);
    chk("rst_mem_str", 32'(mem_str), 32'd0);
    chk("rst_mem_mode", 32'(mem_mode), 32'd0);
    chk("rst_mem_addr", 32'(mem_addr), 32'd0);
    chk("rst_mem_din", mem_din, 32'd0);
    chk("rst_cnt_load", 32'(cnt_load), 32'd0);
    chk("rst_cnt_store", 32'(cnt_store), 32'd0);
    chk("rst_cnt_err", 32'(cnt_err), 32'd0);
    chk("rst_sat_cnt_err", 32'(s_cnt_err), 32'd0);
  endtask

  // Issue one request from a negedge; returns at posedge+1 once RESP is entered.
  task automatic send(input logic we, input logic [1:0] size, input logic sgn,
                      input logic [11:0] addr, input logic [31:0] wdata,
                      input logic [31:0] exp_rd, input logic exp_err);
    chk("req_ready_idle", 32'(req_ready), 32'd1);
    req_valid  = 1'b1;
    req_we     = we;
    req_size   = size;
    req_signed = sgn;
    req_addr   = addr;
    req_wdata  = wdata;
    exp_q.push_back({exp_err, exp_rd});
    @(posedge clk);
    #1;
    // Scramble the request bus: the DUT must work from its registered copy.
    req_valid = 1'b0;
    req_we    = ~we;
    req_addr  = ~addr;
    req_wdata = ~wdata;
    req_size  = ~size;
    if (exp_err) begin
      chk("err_rsp_latency", 32'(rsp_valid), 32'd1);
      chk("err_no_str", 32'(mem_str), 32'd0);
      exp_errs++;
    end else begin
      chk("acc_rsp_valid", 32'(rsp_valid), 32'd0);
      chk("acc_req_ready", 32'(req_ready), 32'd0);
      chk("acc_mem_str", 32'(mem_str), 32'(we));
      chk("acc_mem_addr", 32'(mem_addr), 32'(addr));
      chk("acc_mem_mode", 32'(mem_mode), 32'(size));
      if (we) chk("acc_mem_din", mem_din, wdata);
      @(posedge clk);
      #1;
      chk("rsp_latency", 32'(rsp_valid), 32'd1);
      chk("rsp_no_str", 32'(mem_str), 32'd0);
      if (we) exp_stores++;
      else    exp_loads++;
    end
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    @(negedge clk);
    while (!req_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!req_ready) begin
      checks++;
      failures++;
      $display("FAIL idle_timeout got req_ready=%b exp 1", req_ready);
    end
  endtask

  task automatic check_counts(input string tag);
    chk({tag, "_cnt_load"}, 32'(cnt_load), 32'(exp_loads));
    chk({tag, "_cnt_store"}, 32'(cnt_store), 32'(exp_stores));
    chk({tag, "_cnt_err"}, 32'(cnt_err), 32'(exp_errs));
  endtask

  initial begin
    int n;
    int str_before;
    clr_n      = 1'b0;
    mem_fill   = 1'b1;
    req_valid  = 1'b0;
    req_we     = 1'b0;
    req_size   = SZ_WORD;
    req_signed = 1'b0;
    req_addr   = 12'h0;
    req_wdata  = 32'h0;
    rsp_ready  = 1'b1;
    repeat (2) @(negedge clk);
    mem_fill = 1'b0;
    check_reset_vals();
    clr_n = 1'b1;
    @(negedge clk);

    // Word store then word load
    send(1'b1, SZ_WORD, 1'b0, 12'h010, 32'hDEADBEEF, 32'h0, 1'b0);
    wait_idle();
    chk("str_one_cycle", 32'(str_cycles), 32'd1);
    send(1'b0, SZ_WORD, 1'b0, 12'h010, 32'h0, 32'hDEADBEEF, 1'b0);
    wait_idle();
    check_counts("t1");

    // Byte store at 0x013 (bytes now EF BE AD 80), then extensions
    send(1'b1, SZ_BYTE, 1'b0, 12'h013, 32'h00000080, 32'h0, 1'b0);
    wait_idle();
    send(1'b0, SZ_BYTE, 1'b1, 12'h013, 32'h0, 32'hFFFFFF80, 1'b0);
    wait_idle();
    send(1'b0, SZ_BYTE, 1'b0, 12'h013, 32'h0, 32'h00000080, 1'b0);
    wait_idle();
    send(1'b0, SZ_HALF, 1'b1, 12'h012, 32'h0, 32'hFFFF80AD, 1'b0);
    wait_idle();
    send(1'b0, SZ_HALF, 1'b0, 12'h012, 32'h0, 32'h000080AD, 1'b0);
    wait_idle();
    send(1'b0, SZ_WORD, 1'b1, 12'h010, 32'h0, 32'h80ADBEEF, 1'b0);
    wait_idle();
    send(1'b1, SZ_HALF, 1'b0, 12'h032, 32'h0000C3D2, 32'h0, 1'b0);
    wait_idle();
    send(1'b0, SZ_HALF, 1'b1, 12'h032, 32'h0, 32'hFFFFC3D2, 1'b0);
    wait_idle();
    send(1'b0, SZ_BYTE, 1'b1, 12'h031, 32'h0, 32'h00000031, 1'b0);
    wait_idle();
    check_counts("t2");

    // Error requests: no memory strobe, only cnt_err moves
    str_before = str_cycles;
    send(1'b0, SZ_HALF, 1'b1, 12'h021, 32'h0, 32'h0, 1'b1);
    wait_idle();
    send(1'b0, SZ_WORD, 1'b0, 12'h022, 32'h0, 32'h0, 1'b1);
    wait_idle();
    send(1'b0, SZ_ILLEGAL, 1'b0, 12'h020, 32'h0, 32'h0, 1'b1);
    wait_idle();
    send(1'b1, SZ_WORD, 1'b0, 12'h011, 32'h11111111, 32'h0, 1'b1);
    wait_idle();
    chk("err_no_strobes", 32'(str_cycles), 32'(str_before));
    check_counts("t3");
    send(1'b0, SZ_WORD, 1'b0, 12'h010, 32'h0, 32'h80ADBEEF, 1'b0);
    wait_idle();

    // Response stall with rsp_ready low
    rsp_ready = 1'b0;
    send(1'b0, SZ_BYTE, 1'b1, 12'h012, 32'h0, 32'hFFFFFFAD, 1'b0);
    repeat (5) begin
      @(negedge clk);
      chk("stall_rsp_valid", 32'(rsp_valid), 32'd1);
      chk("stall_rsp_rdata", rsp_rdata, 32'hFFFFFFAD);
      chk("stall_req_ready", 32'(req_ready), 32'd0);
    end
    @(posedge clk);
    #1;
    rsp_ready = 1'b1;
    @(posedge clk);
    #1;
    chk("stall_idle_ready", 32'(req_ready), 32'd1);
    chk("stall_idle_valid", 32'(rsp_valid), 32'd0);
    chk("stall_popped", 32'(exp_q.size()), 32'd0);
    @(negedge clk);

    // Reset in the middle of a store ACCESS
    req_valid = 1'b1;
    req_we    = 1'b1;
    req_size  = SZ_WORD;
    req_addr  = 12'h040;
    req_wdata = 32'h12345678;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    chk("rst_pre_str", 32'(mem_str), 32'd1);
    #2;
    clr_n = 1'b0;
    #1;
    check_reset_vals();
    repeat (2) @(negedge clk);
    clr_n = 1'b1;
    exp_loads  = 0;
    exp_stores = 0;
    exp_errs   = 0;
    send(1'b0, SZ_WORD, 1'b0, 12'h040, 32'h0, 32'h43424140, 1'b0);
    wait_idle();
    check_counts("t5");

    // Error counter saturation on the 2-bit instance
    send(1'b0, SZ_HALF, 1'b0, 12'h041, 32'h0, 32'h0, 1'b1);
    wait_idle();
    send(1'b0, SZ_WORD, 1'b0, 12'h043, 32'h0, 32'h0, 1'b1);
    wait_idle();
    chk("sat_cnt_err_2", 32'(s_cnt_err), 32'd2);
    send(1'b1, SZ_WORD, 1'b0, 12'h042, 32'h0, 32'h0, 1'b1);
    wait_idle();
    chk("sat_cnt_err_3", 32'(s_cnt_err), 32'd3);
    send(1'b0, SZ_ILLEGAL, 1'b0, 12'h044, 32'h0, 32'h0, 1'b1);
    wait_idle();
    chk("sat_cnt_err_hold", 32'(s_cnt_err), 32'd3);
    check_counts("t6");

    n = 0;
    while (exp_q.size() != 0 && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got timeout exp completion");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire

// File: doc/lsu_mem_ctrl.md
# lsu_mem_ctrl

Load/store controller sitting directly upstream of the 2-way byte-addressable data memory in the MIPS datapath. Accepts one memory request at a time from the execute stage over a valid/ready handshake, checks alignment, drives the memory's str/mode/address/data_in port for exactly one cycle, sign- or zero-extends load data, and returns a response over a second valid/ready handshake. Keeps saturating load/store/error counters for debug.

## Interface
- AWIDTH, 12: byte-address width; matches the data memory address port.
- DWIDTH, 32: data width; fixed at 32, other values unsupported.
- CWIDTH, 16: width of each statistics counter.

- clk  in  1  single clock; all state updates on rising edge.
- clr_n  in  1  asynchronous, active-low reset.
- req_valid  in  1  request present.
- req_ready  out  1  controller can accept; high only in IDLE.
- req_we  in  1  1 = store, 0 = load.
- req_size  in  2  00 word, 01 byte, 10 half, 11 illegal. Same encoding as the memory mode port.
- req_signed  in  1  loads only; 1 = sign-extend, 0 = zero-extend.
- req_addr  in  AWIDTH  byte address.
- req_wdata  in  32  store data, right-aligned: byte in [7:0], half in [15:0].
- rsp_valid  out  1  response present.
- rsp_ready  in  1  consumer accepts response.
- rsp_rdata  out  32  extended load data; 0 for stores and errors.
- rsp_err  out  1  misaligned or illegal-size request; no memory access was made.
- mem_str  out  1  memory write strobe.
- mem_mode  out  2  memory access mode.
- mem_addr  out  AWIDTH  memory byte address.
- mem_din  out  32  memory write data; passed through unshifted because the memory lane-shifts internally.
- mem_dout  in  32  memory combinational read data, right-aligned, unused upper bits zero.
- cnt_load, cnt_store, cnt_err  out  CWIDTH each  saturating event counters.

## Operation
- The FSM has three states: IDLE, ACCESS, RESP.
- IDLE:
  - req_ready = 1.
  - When req_valid = 1, all req_* fields are registered.
  - An error is flagged if any of these hold: size = 11, half with addr[0] = 1, or word with addr[1:0] ≠ 00.
  - On error, go to RESP with err = 1 and rdata = 0, and increment cnt_err.
  - Otherwise, go to ACCESS.
- ACCESS (exactly one cycle):
  - mem_mode and mem_addr come from the registered request.
  - mem_str = registered we.
  - For a load, capture the extended mem_dout into rsp_rdata at the closing edge. For a store, set rdata = 0.
  - Increment cnt_load or cnt_store. Go to RESP.
- RESP:
  - rsp_valid = 1. rsp_rdata and rsp_err are held stable.
  - When rsp_ready = 1, go to IDLE.
- Extension rules:
  - Byte: signed gives {24{d[7]}, d[7:0]}; unsigned gives {24'b0, d[7:0]}.
  - Half: the same pattern using d[15].
  - Word: passed through unchanged.
- mem_str is decoded from state only (ACCESS && we). It is never asserted outside ACCESS.
- Counters stick at all-ones.

## Timing
- Reset (clr_n = 0, asynchronous):
  - State goes to IDLE.
  - req_ready = 1, rsp_valid = 0, rsp_rdata = 0, rsp_err = 0.
  - mem_str = 0, mem_mode = 00, mem_addr = 0, mem_din = 0.
  - All counters = 0.
  - Reset asserted during ACCESS drops mem_str in the same cycle, and no write may complete.
- Latency:
  - Request accepted at edge N: ACCESS spans N→N+1; rsp_valid rises after edge N+1.
  - Error request: rsp_valid rises after edge N.
- Throughput: at best one request per 3 cycles (2 for errors). req_ready is low in ACCESS and RESP.
- Store: the memory writes at the edge that ends ACCESS.
- Load: mem_dout is sampled at that same edge.
- Handshake rules:
  - A response held with rsp_ready = 0 stalls indefinitely with outputs stable.
  - req_valid while not ready is ignored. The requester must hold it.
  - No combinational path from rsp_ready to req_ready.
- Outside ACCESS, mem_addr, mem_mode and mem_din hold their last registered values; only mem_str is gated.

## Structure
- Shared package holds:
  - size constants SZ_WORD = 2'b00, SZ_BYTE = 2'b01, SZ_HALF = 2'b10, shared with the data memory mode decode;
  - FSM state encoding;
  - the alignment-check function.
- One sub-module: load_extend, purely combinational (size, signed, din → dout). It is reused by any future uncached I/O path.

## Test plan
- Store word 0xDEADBEEF to 0x010, then load word from 0x010 → mem_str high for one cycle only; rsp_rdata = 0xDEADBEEF, rsp_err = 0, response 2 cycles after accept; cnt_store = 1, cnt_load = 1.
- Store byte 0x80 to 0x013, then load signed byte from 0x013 → 0xFFFFFF80; unsigned load of the same byte → 0x00000080.
- Load half from 0x021, then word from 0x022, then size 11 → each gives rsp_err = 1 and rdata = 0, with mem_str never asserted; cnt_err = 3 and the load counter is unchanged.
- Hold rsp_ready = 0 for 5 cycles after a load → rsp_valid and rdata stable and req_ready = 0 throughout; accepted on the first cycle rsp_ready = 1, with IDLE on the next cycle.
- Pulse clr_n low mid-ACCESS of a store of 0x12345678 to 0x040 → mem_str drops immediately, a later load of 0x040 returns the old value, and all outputs match the reset values.
- Force cnt_err to all-ones minus 1, then issue 3 misaligned requests → cnt_err saturates at 0xFFFF.
